// File: rtl/bcd_scan_pkg.sv
// Shared constants for the BCD scan counter: digit limit, segment patterns
// and the load-value digit sanitiser.
`timescale 1ns/1ps
package bcd_scan_pkg;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; entry [n] is the pattern for digit n, dp always off.
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [3:0] bcd_sanitize(input logic [3:0] d);
    if (d > BCD_MAX) begin
      return 4'd0;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Single-digit BCD to active-low 7-segment decoder; non-BCD codes blank the digit.
`timescale 1ns/1ps
module bcd_seg_decode
  import bcd_scan_pkg::*;
(
  input  logic [3:0] value,
  output logic [7:0] seg
);

  // Table lookup for legal digits, blank for anything above nine.
  always_comb begin
    seg = SEG_BLANK;
    if (value <= BCD_MAX) begin
      seg = SEG_TABLE[value];
    end else begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Prescaled up/down BCD counter with loadable value and a multiplexed,
// active-low 7-segment scan output.
`timescale 1ns/1ps
module bcd_scan_counter
  import bcd_scan_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 4194304,
  parameter int SCAN_DIV = 65536
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  EN,
  input  logic                  DIR,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   data,
  output logic                  CO,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]          presc_r;
  logic [SW-1:0]          scan_cnt_r;
  logic [IW-1:0]          idx_r;
  logic                   tick_s;
  logic                   wrap_s;
  logic [DIGITS-1:0]      sat_s;
  logic [DIGITS-1:0]      cin_s;
  logic [4*DIGITS-1:0]    data_next_s;
  logic [4*DIGITS-1:0]    load_val_s;
  logic [3:0]             digit_sel_s;

  assign tick_s = EN && (presc_r == PRESC_LAST);
  assign wrap_s = &sat_s;

  // A digit rolls over when every lower digit is saturated (9 going up, 0 going down).
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] cur_s;
    logic [3:0] nxt_s;

    assign cur_s    = data[4*i +: 4];
    assign sat_s[i] = DIR ? (cur_s == BCD_MAX) : (cur_s == 4'd0);

    if (i == 0) begin : g_lsd
      assign cin_s[i] = 1'b1;
    end else begin : g_upper
      assign cin_s[i] = &sat_s[i-1:0];
    end

    // Next value of this digit for a tick with the current direction.
    always_comb begin
      nxt_s = cur_s;
      if (!cin_s[i]) begin
        nxt_s = cur_s;
      end else if (sat_s[i]) begin
        nxt_s = DIR ? 4'd0 : BCD_MAX;
      end else if (DIR) begin
        nxt_s = cur_s + 4'd1;
      end else begin
        nxt_s = cur_s - 4'd1;
      end
    end

    assign data_next_s[4*i +: 4] = nxt_s;
    assign load_val_s[4*i +: 4]  = bcd_sanitize(LOAD_VAL[4*i +: 4]);
  end

  // Prescaler, count and carry-out; load overrides any tick in the same cycle.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      data    <= '0;
      presc_r <= '0;
      CO      <= 1'b0;
    end else if (LOAD) begin
      data    <= load_val_s;
      presc_r <= '0;
      CO      <= 1'b0;
    end else begin
      if (EN) begin
        presc_r <= tick_s ? '0 : presc_r + PW'(1);
      end
      if (tick_s) begin
        data <= data_next_s;
      end
      CO <= tick_s && wrap_s;
    end
  end

  // Free-running digit scan, independent of EN and LOAD.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      scan_cnt_r <= '0;
      idx_r      <= '0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= '0;
      idx_r      <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
    end else begin
      scan_cnt_r <= scan_cnt_r + SW'(1);
    end
  end

  assign an          = ~(DIGITS'(1) << idx_r);
  assign digit_sel_s = data[{idx_r, 2'b00} +: 4];

  bcd_seg_decode u_seg_decode (
    .value (digit_sel_s),
    .seg   (seg)
  );

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench: a decimal-integer model predicts data/CO/an/seg per cycle.
`timescale 1ns/1ps
module tb_bcd_scan_counter;

  typedef struct packed {
    logic [15:0] data;
    logic        co;
    logic [3:0]  an;
    logic [7:0]  seg;
  } obs_t;

  logic        CLK = 1'b0;
  logic        CLR, EN, DIR, LOAD;
  logic [15:0] LOAD_VAL;
  logic [15:0] data;
  logic        CO;
  logic [3:0]  an;
  logic [7:0]  seg;

  logic        CLR2, EN2, DIR2, LOAD2;
  logic [23:0] LOAD_VAL2;
  logic [23:0] data2;
  logic        CO2;
  logic [5:0]  an2;
  logic [7:0]  seg2;

  int ncmp = 0;
  int nerr = 0;
  obs_t exp_q[$];
  obs_t obs_q[$];

  int m_val, m_presc, m_scnt, m_idx;
  bit m_co;

  always #5 CLK = ~CLK;

  bcd_scan_counter #(.DIGITS(4), .PRESCALE(4), .SCAN_DIV(2)) dut (
    .CLK(CLK), .CLR(CLR), .EN(EN), .DIR(DIR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .data(data), .CO(CO), .an(an), .seg(seg)
  );

  bcd_scan_counter #(.DIGITS(6), .PRESCALE(2), .SCAN_DIV(2)) dut6 (
    .CLK(CLK), .CLR(CLR2), .EN(EN2), .DIR(DIR2), .LOAD(LOAD2), .LOAD_VAL(LOAD_VAL2),
    .data(data2), .CO(CO2), .an(an2), .seg(seg2)
  );

  function automatic logic [7:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int acc;
    logic [3:0] d;
    acc = 0;
    for (int i = 3; i >= 0; i--) begin
      d = lv[4*i +: 4];
      acc = acc * 10 + ((d > 4'd9) ? 0 : int'(d));
    end
    return acc;
  endfunction

  task automatic model_reset();
    m_val = 0; m_presc = 0; m_scnt = 0; m_idx = 0; m_co = 1'b0;
  endtask

  // Predict the post-edge state from the inputs now applied, then advance one clock.
  task automatic cycles(input int n);
    obs_t e;
    bit tick;
    for (int k = 0; k < n; k++) begin
      if (LOAD) begin
        m_val = from_load(LOAD_VAL); m_presc = 0; m_co = 1'b0;
      end else if (EN) begin
        tick = (m_presc == 3);
        m_presc = tick ? 0 : m_presc + 1;
        m_co = 1'b0;
        if (tick && DIR) begin
          m_val = m_val + 1;
          if (m_val == 10000) begin m_val = 0; m_co = 1'b1; end
        end else if (tick) begin
          if (m_val == 0) begin m_val = 9999; m_co = 1'b1; end
          else m_val = m_val - 1;
        end
      end else begin
        m_co = 1'b0;
      end
      if (m_scnt == 1) begin m_scnt = 0; m_idx = (m_idx + 1) % 4; end
      else m_scnt = m_scnt + 1;
      e.data = to_bcd(m_val);
      e.co   = m_co;
      e.an   = ~(4'b0001 << m_idx);
      e.seg  = seg_of(e.data[4*m_idx +: 4]);
      exp_q.push_back(e);
      @(posedge CLK); #1;
      obs_q.push_back({data, CO, an, seg});
    end
  endtask

  task automatic test_reset();
    #12;
    ncmp++; if (data !== 16'h0000) begin nerr++; $display("FAIL reset_data: got %h want 0000", data); end
    ncmp++; if (CO !== 1'b0) begin nerr++; $display("FAIL reset_co: got %b want 0", CO); end
    ncmp++; if (an !== 4'b1110) begin nerr++; $display("FAIL reset_an: got %b want 1110", an); end
    ncmp++; if (seg !== 8'hC0) begin nerr++; $display("FAIL reset_seg: got %h want c0", seg); end
    CLR = 1'b1;
    model_reset();
  endtask

  task automatic test_count_up();
    obs_t e, o;
    EN = 1'b1; DIR = 1'b1;
    cycles(40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL count_up: got %h/%b/%b/%h want %h/%b/%b/%h", o.data, o.co, o.an, o.seg, e.data, e.co, e.an, e.seg); end
    end
    ncmp++; if (data !== 16'h0010) begin nerr++; $display("FAIL count_up_40: got %h want 0010", data); end
  endtask

  task automatic test_wrap_up();
    obs_t e, o;
    int co_cnt;
    co_cnt = 0;
    LOAD_VAL = 16'h9998; LOAD = 1'b1; DIR = 1'b1;
    cycles(1);
    LOAD = 1'b0;
    cycles(11);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); ncmp++;
      co_cnt += int'(o.co);
      if (o !== e) begin nerr++; $display("FAIL wrap_up: got %h/%b/%b/%h want %h/%b/%b/%h", o.data, o.co, o.an, o.seg, e.data, e.co, e.an, e.seg); end
    end
    ncmp++; if (co_cnt != 1) begin nerr++; $display("FAIL wrap_up_co_count: got %0d want 1", co_cnt); end
    ncmp++; if (data !== 16'h0000) begin nerr++; $display("FAIL wrap_up_data: got %h want 0000", data); end
  endtask

  task automatic test_count_down();
    obs_t e, o;
    DIR = 1'b0; LOAD_VAL = 16'h1000; LOAD = 1'b1;
    cycles(1);
    LOAD = 1'b0;
    cycles(4);
    ncmp++; if (data !== 16'h0999) begin nerr++; $display("FAIL down_borrow: got %h want 0999", data); end
    LOAD_VAL = 16'h0000; LOAD = 1'b1;
    cycles(1);
    LOAD = 1'b0;
    cycles(4);
    ncmp++; if ({data, CO} !== {16'h9999, 1'b1}) begin nerr++; $display("FAIL down_wrap: got %h co=%b want 9999 co=1", data, CO); end
    cycles(1);
    ncmp++; if (CO !== 1'b0) begin nerr++; $display("FAIL down_co_width: got %b want 0", CO); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL count_down: got %h/%b/%b/%h want %h/%b/%b/%h", o.data, o.co, o.an, o.seg, e.data, e.co, e.an, e.seg); end
    end
  endtask

  task automatic test_enable_hold();
    obs_t e, o;
    DIR = 1'b1; LOAD_VAL = 16'h0042; LOAD = 1'b1;
    cycles(1);
    LOAD = 1'b0;
    cycles(2);
    EN = 1'b0;
    cycles(100);
    ncmp++; if (data !== 16'h0042) begin nerr++; $display("FAIL en_hold_data: got %h want 0042", data); end
    EN = 1'b1;
    cycles(2);
    ncmp++; if (data !== 16'h0043) begin nerr++; $display("FAIL en_resume: got %h want 0043", data); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL enable_hold: got %h/%b/%b/%h want %h/%b/%b/%h", o.data, o.co, o.an, o.seg, e.data, e.co, e.an, e.seg); end
    end
  endtask

  task automatic test_dir_change();
    obs_t e, o;
    LOAD_VAL = 16'h0500; LOAD = 1'b1; DIR = 1'b1;
    cycles(1);
    LOAD = 1'b0;
    cycles(1);
    DIR = 1'b0;
    cycles(2);
    DIR = 1'b1;
    cycles(1);
    ncmp++; if (data !== 16'h0501) begin nerr++; $display("FAIL dir_change: got %h want 0501", data); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL dir_change_seq: got %h/%b/%b/%h want %h/%b/%b/%h", o.data, o.co, o.an, o.seg, e.data, e.co, e.an, e.seg); end
    end
  endtask

  task automatic test_load_on_tick();
    obs_t e, o;
    LOAD_VAL = 16'h0100; LOAD = 1'b1;
    cycles(1);
    LOAD = 1'b0;
    cycles(3);
    LOAD_VAL = 16'h12A4; LOAD = 1'b1;
    cycles(1);
    LOAD = 1'b0;
    ncmp++; if (data !== 16'h1204) begin nerr++; $display("FAIL load_on_tick: got %h want 1204", data); end
    cycles(3);
    ncmp++; if (data !== 16'h1204) begin nerr++; $display("FAIL load_presc_cleared: got %h want 1204", data); end
    cycles(1);
    ncmp++; if (data !== 16'h1205) begin nerr++; $display("FAIL load_next_tick: got %h want 1205", data); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL load_on_tick_seq: got %h/%b/%b/%h want %h/%b/%b/%h", o.data, o.co, o.an, o.seg, e.data, e.co, e.an, e.seg); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    LOAD_VAL = 16'h5555; LOAD = 1'b1; CLR = 1'b0;
    #1;
    ncmp++; if ({data, CO, an, seg} !== {16'h0000, 1'b0, 4'b1110, 8'hC0}) begin nerr++; $display("FAIL clr_async: got %h/%b/%b/%h want 0000/0/1110/c0", data, CO, an, seg); end
    @(posedge CLK); #1;
    ncmp++; if (data !== 16'h0000) begin nerr++; $display("FAIL clr_beats_load: got %h want 0000", data); end
    LOAD = 1'b0; CLR = 1'b1;
    model_reset();
    cycles(4);
    ncmp++; if (data !== 16'h0001) begin nerr++; $display("FAIL clr_resume: got %h want 0001", data); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL reset_mid_seq: got %h/%b/%b/%h want %h/%b/%b/%h", o.data, o.co, o.an, o.seg, e.data, e.co, e.an, e.seg); end
    end
  endtask

  task automatic test_six_digit_reset();
    CLR2 = 1'b1;
    for (int k = 0; k < 7; k++) begin @(posedge CLK); #1; end
    ncmp++; if (data2 !== 24'h000003) begin nerr++; $display("FAIL six_count: got %h want 000003", data2); end
    CLR2 = 1'b0;
    #1;
    ncmp++; if ({data2, CO2, an2, seg2} !== {24'h000000, 1'b0, 6'b111110, 8'hC0}) begin nerr++; $display("FAIL six_clr: got %h/%b/%b/%h want 000000/0/111110/c0", data2, CO2, an2, seg2); end
    #1;
    CLR2 = 1'b1;
    for (int k = 0; k < 4; k++) begin @(posedge CLK); #1; end
    ncmp++; if (data2 !== 24'h000002) begin nerr++; $display("FAIL six_resume: got %h want 000002", data2); end
  endtask

  initial begin
    CLR = 1'b0; EN = 1'b0; DIR = 1'b1; LOAD = 1'b0; LOAD_VAL = 16'h0000;
    CLR2 = 1'b0; EN2 = 1'b1; DIR2 = 1'b1; LOAD2 = 1'b0; LOAD_VAL2 = 24'h000000;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_count_down();
    test_enable_hold();
    test_dir_change();
    test_load_on_tick();
    test_reset_mid();
    test_six_digit_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
